// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial two's-complement adder/subtractor
// Ports:
//    clk       : clock, rising edge
//    reset_n   : asynchronous active-low reset
//    in_valid  : operand set presented      in_ready  : accepting (IDLE only)
//    a, b      : WIDTH-bit operands          cin       : carry-in (ignored when sub=1)
//    sub       : 0 = a + b, 1 = a - b
//    out_valid : result held (DONE only)     out_ready : consumer takes result
//    s         : WIDTH-bit sum/difference    cout      : MSB carry (1 = no borrow on sub)
//    ovf       : signed overflow
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   generate
      if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
         $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] res;
   logic             carry;
   logic             cout_reg;
   logic             ovf_reg;

   logic [DIGIT:0]   dsum;
   logic             c_msb;

   // One digit of the ripple: low DIGIT bits of both operands plus the
   // carry from the previous digit.
   always_comb begin
      dsum  = {1'b0, a_reg[DIGIT-1:0]} + {1'b0, b_reg[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
      // Carry into the top bit of this digit, recovered from the sum bit
      // and its two addend bits; only meaningful on the final digit.
      c_msb = dsum[DIGIT-1] ^ a_reg[DIGIT-1] ^ b_reg[DIGIT-1];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         cnt      <= '0;
         a_reg    <= '0;
         b_reg    <= '0;
         res      <= '0;
         carry    <= 1'b0;
         cout_reg <= 1'b0;
         ovf_reg  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  // Subtraction is a + ~b + 1.
                  a_reg <= a;
                  b_reg <= b ^ {WIDTH{sub}};
                  carry <= sub | cin;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               a_reg <= a_reg >> DIGIT;
               b_reg <= b_reg >> DIGIT;
               // Digits enter at the MSB end so the first (least significant)
               // digit lands at bit 0 after NDIG shifts.
               res   <= (res >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
               carry <= dsum[DIGIT];
               cnt   <= cnt + CW'(1);
               if (cnt == LAST) begin
                  cout_reg <= dsum[DIGIT];
                  ovf_reg  <= c_msb ^ dsum[DIGIT];
                  state    <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign s         = res;
   assign cout      = cout_reg;
   assign ovf       = ovf_reg;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8: operand and sum width in bits; WIDTH >= 2.
REQ-002 Parameter DIGIT, default 1: bits processed per cycle; WIDTH % DIGIT == 0 is required, and a violation SHALL fire a simulation-time $error.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 in_valid  input  1  operand set presented.
REQ-006 in_ready  output  1  block can accept an operand set.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in; ignored when sub=1.
REQ-010 sub  input  1  mode: 0 = add, 1 = subtract (a - b).
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer takes the result.
REQ-013 s  output  WIDTH  sum or difference.
REQ-014 cout  output  1  carry out of MSB; in subtract mode, 1 means no borrow.
REQ-015 ovf  output  1  two's-complement signed overflow.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE; both are registered-state decodes.
REQ-018 IDLE to RUN on in_valid & in_ready; the same edge SHALL latch a, b^{WIDTH{sub}}, initial carry (sub ? 1 : cin), and clear the digit counter.
REQ-019 Each RUN cycle SHALL add the low DIGIT bits of the A and B registers plus the carry register, then shift both operand registers right by DIGIT.
REQ-020 Each RUN cycle SHALL shift the DIGIT-bit digit sum into the MSB end of the result register and store the digit carry-out in the carry register.
REQ-021 On the final digit (counter == WIDTH/DIGIT-1), the FSM SHALL go RUN to DONE.
REQ-022 On that final edge, cout SHALL take the final carry and ovf SHALL take (carry into bit WIDTH-1) ^ (carry out of bit WIDTH-1).
REQ-023 Latency: out_valid SHALL assert exactly WIDTH/DIGIT rising edges after the accepting edge (8 edges for defaults; 2 edges for WIDTH=8, DIGIT=4).
REQ-024 In DONE, s, cout and ovf SHALL hold stable until the edge where out_ready=1; that edge SHALL move the FSM to IDLE.
REQ-025 in_valid during RUN or DONE SHALL be ignored, with no latching; a new operand set can be accepted no earlier than the cycle after the result is taken.
REQ-026 in_valid and out_ready values in states where they are not consumed SHALL have no effect.
REQ-027 a, b, cin and sub SHALL be sampled only on the accepting edge; later input changes SHALL not affect the result.
REQ-028 Wrap-around: s SHALL be the result modulo 2^WIDTH; the carry out of the MSB appears only on cout.
REQ-029 X-free: no output SHALL go X after reset, regardless of input values in non-consuming states.

Reset
REQ-030 reset_n=0 SHALL asynchronously force: state IDLE, counter 0, operand/result/carry registers 0, s=0, cout=0, ovf=0, out_valid=0.
REQ-031 in_ready SHALL be 1 while reset_n=0 and after it returns high.
REQ-032 Reset asserted during RUN or DONE SHALL abort the operation with no out_valid pulse for it; after release, the next accept SHALL produce a correct result.

Verification
REQ-033 Defaults: a=8'h3C, b=8'h0F, cin=1, sub=0 -> after 8 cycles s=8'h4C, cout=0, ovf=0.
REQ-034 Defaults: a=8'hFF, b=8'h01, cin=0, sub=0 -> s=8'h00, cout=1, ovf=0 (wrap-around); a=8'h7F, b=8'h01 -> s=8'h80, ovf=1.
REQ-035 Defaults: sub=1, a=8'h05, b=8'h07, cin=1 (ignored) -> s=8'hFE, cout=0, ovf=0; a=8'h80, b=8'h01, sub=1 -> s=8'h7F, ovf=1.
REQ-036 WIDTH=8, DIGIT=4: a=8'h9A, b=8'h77, cin=0 -> out_valid on the 2nd edge after accept, s=8'h11, cout=1.
REQ-037 Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 and changing a/b -> s stays constant, in_ready=0; after out_ready=1, the next accept occurs the following cycle.
REQ-038 Exhaustive WIDTH=4, DIGIT in {1,2,4}: all a, b, cin, sub combinations against a reference model; assert reset_n=0 mid-RUN once -> out_valid=0 and outputs zero asynchronously, with no error count increase.
